// File: rtl/seq_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen_if
// Load handshake plus serial stream bundle for seq_pattern_gen.
//
// Signals
//   load_valid    requester -> generator  load request present
//   load_ready    generator -> requester  generator idle, can accept a load
//   load_pattern  requester -> generator  pattern, MSB transmitted first
//   load_repeat   requester -> generator  extra repetitions (instances = +1)
//   load_gap      requester -> generator  idle cycles between instances
//   data_out      generator -> consumer   serial bit (0 when not valid)
//   data_valid    generator -> consumer   data_out carries a pattern bit
//   last_bit      generator -> consumer   final (LSB) bit of an instance
//   done          generator -> consumer   one-cycle end-of-job pulse
//   busy          generator -> consumer   job in progress
//
// Modports: master = requester/consumer side, slave = generator.
// -----------------------------------------------------------------------------
interface seq_pattern_gen_if #(
    parameter int PAT_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [PAT_W-1:0] load_pattern;
    logic [REP_W-1:0] load_repeat;
    logic [GAP_W-1:0] load_gap;
    logic             data_out;
    logic             data_valid;
    logic             last_bit;
    logic             done;
    logic             busy;

    modport master (
        output load_valid,
        output load_pattern,
        output load_repeat,
        output load_gap,
        input  load_ready,
        input  data_out,
        input  data_valid,
        input  last_bit,
        input  done,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_pattern,
        input  load_repeat,
        input  load_gap,
        output load_ready,
        output data_out,
        output data_valid,
        output last_bit,
        output done,
        output busy
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
// Serial bit-pattern transmitter. A parallel pattern is accepted through a
// valid/ready handshake and shifted out MSB-first one bit per clock, repeated
// load_repeat+1 times with load_gap idle cycles between instances.
//
// Ports
//   clk  in   rising-edge clock
//   rst  in   synchronous reset, active-low (0 = reset)
//   bus  slave modport of seq_pattern_gen_if (load handshake + serial stream)
//
// All outputs are decoded from registered state; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_pattern_gen_if.slave   bus
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [PAT_W-1:0] pat_q,   pat_d;
    logic [REP_W-1:0] rep_q,   rep_d;   // instances still to send after the current one
    logic [GAP_W-1:0] gap_q,   gap_d;   // captured gap length
    logic [GAP_W-1:0] gcnt_q,  gcnt_d;  // gap cycles left, including the current one
    logic             done_q,  done_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pat_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // load_ready is 1 throughout IDLE, so load_valid alone is the handshake
                if (bus.load_valid) begin
                    pat_d   = bus.load_pattern;
                    rep_d   = bus.load_repeat;
                    gap_d   = bus.load_gap;
                    idx_d   = IDX_MAX;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (idx_q == '0) begin
                    if (rep_q == '0) begin
                        // Counter is only decremented when non-zero, so it never wraps
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rep_d = rep_q - 1'b1;
                        idx_d = IDX_MAX;
                        if (gap_q != '0) begin
                            gcnt_d  = gap_q;
                            state_d = S_GAP;
                        end
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end

            S_GAP: begin
                gcnt_d = gcnt_q - 1'b1;
                if (gcnt_q == GAP_W'(1)) begin
                    state_d = S_SHIFT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from registered state
    assign bus.load_ready = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.data_valid = (state_q == S_SHIFT);
    assign bus.data_out   = (state_q == S_SHIFT) && pat_q[idx_q];
    assign bus.last_bit   = (state_q == S_SHIFT) && (idx_q == '0);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;

    localparam int PAT_W = 4;
    localparam int REP_W = 4;
    localparam int GAP_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_pattern_gen_if #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) bus ();

    seq_pattern_gen #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int   cyc;
        logic v;
        logic d;
        logic l;
        logic dn;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   busy_end = -1;
    int   chk_en   = -1;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Reference model: a job accepted in cycle n expands into its full list of
    // timed bit records plus the done record.
    task automatic model_job(input int n, input logic [PAT_W-1:0] p,
                             input int r, input int g);
        int   t;
        exp_t e;
        t = n + 1;
        for (int k = 0; k <= r; k++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                e.cyc = t; e.v = 1'b1; e.d = p[b]; e.l = (b == 0); e.dn = 1'b0;
                sb.push_back(e);
                t++;
            end
            if (k < r) t += g;
        end
        e.cyc = t; e.v = 1'b0; e.d = 1'b0; e.l = 1'b0; e.dn = 1'b1;
        sb.push_back(e);
        busy_end = t - 1;
    endtask

    // Monitor + model step, sampled away from the active edge
    always @(negedge clk) begin
        exp_t e;
        logic presented;
        if (chk_en >= 0 && cyc >= chk_en) begin
            presented = bus.data_valid || bus.done;
            if (presented || (sb.size() > 0 && sb[0].cyc == cyc)) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output cycle %0d: valid=%b done=%b, expected no output",
                             cyc, bus.data_valid, bus.done);
                end else begin
                    e = sb.pop_front();
                    chk("data_valid", 32'(bus.data_valid), 32'(e.v));
                    chk("data_out",   32'(bus.data_out),   32'(e.d));
                    chk("last_bit",   32'(bus.last_bit),   32'(e.l));
                    chk("done",       32'(bus.done),       32'(e.dn));
                end
            end
            if (!bus.data_valid) begin
                chk("idle_data_out", 32'(bus.data_out), 32'd0);
                chk("idle_last_bit", 32'(bus.last_bit), 32'd0);
            end
            chk("busy",       32'(bus.busy),       32'(cyc <= busy_end));
            chk("load_ready", 32'(bus.load_ready), 32'(cyc > busy_end));
        end
        if (!rst) begin
            sb.delete();
            busy_end = cyc;
            if (chk_en < 0) chk_en = cyc + 1;
        end else if (chk_en >= 0 && bus.load_valid && cyc > busy_end) begin
            model_job(cyc, bus.load_pattern, int'(bus.load_repeat), int'(bus.load_gap));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for readiness (scattering ignored junk loads meanwhile), then load.
    task automatic send(input logic [PAT_W-1:0] p, input logic [REP_W-1:0] r,
                        input logic [GAP_W-1:0] g);
        int waitc = 0;
        while (!bus.load_ready && waitc < 400) begin
            bus.load_valid   = ($urandom_range(0, 3) == 0);
            bus.load_pattern = PAT_W'($urandom);
            bus.load_repeat  = REP_W'($urandom);
            bus.load_gap     = GAP_W'($urandom);
            step(1);
            waitc++;
        end
        if (waitc >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout cycle %0d: load_ready=%b, expected 1 within 400 cycles",
                     cyc, bus.load_ready);
        end
        bus.load_valid   = 1'b1;
        bus.load_pattern = p;
        bus.load_repeat  = r;
        bus.load_gap     = g;
        step(1);
        bus.load_valid   = 1'b0;
    endtask

    task automatic wait_idle();
        int waitc = 0;
        while (sb.size() != 0 && waitc < 400) begin
            step(1);
            waitc++;
        end
        if (waitc >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout cycle %0d: %0d records pending, expected 0",
                     cyc, sb.size());
        end
        step(2);
    endtask

    initial begin
        rst              = 1'b0;
        bus.load_valid   = 1'b0;
        bus.load_pattern = '0;
        bus.load_repeat  = '0;
        bus.load_gap     = '0;
        step(3);
        rst = 1'b1;
        step(2);

        // Single instance
        send(4'b0110, 4'd0, 4'd0);
        wait_idle();

        // Back-to-back repetitions
        send(4'b0110, 4'd2, 4'd0);
        wait_idle();

        // Gap insertion
        send(4'b1011, 4'd1, 4'd3);
        wait_idle();

        // Load while busy: pulses in cycles 3 and 9 of the job
        send(4'b0110, 4'd2, 4'd0);
        step(2);
        bus.load_valid = 1'b1; bus.load_pattern = 4'b1111;
        step(1);
        bus.load_valid = 1'b0;
        step(5);
        bus.load_valid = 1'b1;
        step(1);
        bus.load_valid = 1'b0;
        wait_idle();

        // Continuous load_valid
        bus.load_valid   = 1'b1;
        bus.load_pattern = 4'b0110;
        bus.load_repeat  = '0;
        bus.load_gap     = '0;
        step(12);
        bus.load_valid   = 1'b0;
        wait_idle();

        // Reset mid-stream in cycle 2, then fresh load
        send(4'b0110, 4'd2, 4'd0);
        step(1);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(4);
        send(4'b1001, 4'd0, 4'd0);
        wait_idle();

        // Counter and gap extremes
        send(4'b1001, 4'd15, 4'd0);
        wait_idle();
        send(4'b0101, 4'd1, 4'd15);
        wait_idle();

        // Randomized jobs with occasional junk loads and resets
        for (int j = 0; j < 40; j++) begin
            send(PAT_W'($urandom), REP_W'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? GAP_W'(15) : GAP_W'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) begin
                step($urandom_range(0, 6));
                rst = 1'b0;
                step($urandom_range(1, 2));
                rst = 1'b1;
            end
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
